// File: rtl/uart_tx_queue_if.sv
// Handshake bundle between the CPU/sender side and the UART transmit queue.
// Master drives writes and sender status; slave is the queue itself.
interface uart_tx_queue_if #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          clr_ovf;
  logic          tx_busy;
  logic          tx_done;
  logic [7:0]    tx_data;
  logic          tx_trigger;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          in_flight;

  modport master (
    output wr_en, wr_data, flush, clr_ovf, tx_busy, tx_done,
    input  tx_data, tx_trigger, full, empty, count, overflow, in_flight
  );

  modport slave (
    input  wr_en, wr_data, flush, clr_ovf, tx_busy, tx_done,
    output tx_data, tx_trigger, full, empty, count, overflow, in_flight
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO in front of a UART sender: queues CPU writes and hands them out
// one at a time with a trigger pulse, waiting for the sender's done pulse.
//
// state     | meaning
// IDLE      | waiting for a queued byte and a free sender; pops on entry to ISSUE
// ISSUE     | tx_trigger high for this single cycle
// WAIT_DONE | byte handed off, waiting for tx_done
// GAP       | one idle cycle between consecutive triggers
module uart_tx_queue #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic            sysclk,
  input  logic            reset,
  uart_tx_queue_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_trigger_q, tx_trigger_d;
  logic          in_flight_q, in_flight_d;
  logic          overflow_q, overflow_d;

  logic          has_room;
  logic          pop;
  logic          accept;
  logic          drop;

  always_comb begin
    has_room = (count_q < CW'(DEPTH));
    // A flush in the same cycle suppresses the pop so the discarded head never launches
    pop      = (state_q == IDLE) && (count_q != '0) && !bus.tx_busy && !bus.flush;
    accept   = bus.wr_en && !bus.flush && (has_room || pop);
    drop     = bus.wr_en && !bus.flush && !(has_room || pop);

    state_d      = state_q;
    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    tx_data_d    = tx_data_q;
    tx_trigger_d = 1'b0;
    in_flight_d  = in_flight_q;
    overflow_d   = drop | (overflow_q & ~bus.clr_ovf);

    if (accept) begin
      mem_d[wr_ptr_q] = bus.wr_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      tx_data_d = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + PW'(1);
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (bus.flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d      = ISSUE;
          tx_trigger_d = 1'b1;
          in_flight_d  = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.tx_done) begin
          state_d     = GAP;
          in_flight_d = 1'b0;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        in_flight_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      tx_data_q    <= 8'h00;
      tx_trigger_q <= 1'b0;
      in_flight_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      tx_data_q    <= tx_data_d;
      tx_trigger_q <= tx_trigger_d;
      in_flight_q  <= in_flight_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_trigger = tx_trigger_q;
  assign bus.in_flight  = in_flight_q;
  assign bus.overflow   = overflow_q;
  assign bus.count      = count_q;
  assign bus.full       = (count_q == CW'(DEPTH));
  assign bus.empty      = (count_q == '0);

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of FIFO byte entries (power of two, 2..16).
REQ-002 The block SHALL have parameter CW, default 4, meaning the count width, equal to log2(DEPTH)+1.
REQ-003 The block SHALL have port sysclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: CPU write strobe, one byte per high cycle.
REQ-006 The block SHALL have port wr_data, input, 8 bits: the byte to enqueue.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous discard of all queued bytes.
REQ-008 The block SHALL have port clr_ovf, input, 1 bit: synchronous clear of the overflow flag.
REQ-009 The block SHALL have port tx_busy, input, 1 bit: sender work state; high while the sender is shifting a frame.
REQ-010 The block SHALL have port tx_done, input, 1 bit: sender finish, a one-cycle pulse synchronous to sysclk.
REQ-011 The block SHALL have port tx_data, output, 8 bits: the byte presented to the sender writedata.
REQ-012 The block SHALL have port tx_trigger, output, 1 bit: one-cycle send request to the sender.
REQ-013 The block SHALL have port full, output, 1 bit: high when count equals DEPTH.
REQ-014 The block SHALL have port empty, output, 1 bit: high when count equals 0.
REQ-015 The block SHALL have port count, output, CW bits: the number of queued bytes, 0..DEPTH.
REQ-016 The block SHALL have port overflow, output, 1 bit: sticky flag recording a dropped write.
REQ-017 The block SHALL have port in_flight, output, 1 bit: high from tx_trigger until the matching tx_done is accepted.

Function
REQ-018 The FIFO SHALL be circular, with read and write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-019 A write SHALL be accepted when wr_en=1 and (count<DEPTH or a pop occurs in the same cycle); otherwise it SHALL be dropped and overflow set to 1.
REQ-020 Count SHALL be updated as follows on the same edge:
- +1 on accept only
- -1 on pop only
- unchanged on simultaneous accept and pop
REQ-021 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT_DONE and GAP.
REQ-022 The IDLE transition SHALL be: when empty=0 and tx_busy=0, pop the head byte into the tx_data register and go to ISSUE; otherwise stay in IDLE.
REQ-023 In ISSUE, tx_trigger=1 for exactly that one cycle, in_flight=1, and the next state SHALL be WAIT_DONE.
REQ-024 In WAIT_DONE, on tx_done=1 the FSM SHALL clear in_flight and go to GAP; otherwise it stays in WAIT_DONE indefinitely.
REQ-025 GAP SHALL last one cycle and then return to IDLE, giving a minimum 1-cycle idle spacing between trigger pulses.
REQ-026 A tx_done pulse received outside WAIT_DONE SHALL be ignored.
REQ-027 Latency: for a byte accepted at edge N into an empty queue, with the FSM in IDLE and tx_busy=0:
- the pop occurs at edge N+1
- tx_trigger is high in the cycle following edge N+1
REQ-028 tx_data SHALL be registered and held stable from the pop until the next pop.
REQ-029 Flush SHALL zero count and both pointers on the next edge, and set empty=1.
REQ-030 Flush SHALL NOT abort the in-flight byte; the FSM completes WAIT_DONE normally.
REQ-031 Flush SHALL take priority over a simultaneous write; that write is discarded without setting overflow.
REQ-032 clr_ovf SHALL clear overflow; if clr_ovf coincides with a new drop, overflow SHALL remain 1.
REQ-033 Bytes SHALL leave in strict write order; no byte is duplicated or lost except by flush or overflow drop.

Reset
REQ-034 While reset=0, the block SHALL asynchronously force:
- the FSM to IDLE
- pointers and count to 0
- tx_data=8'h00, tx_trigger=0, in_flight=0, overflow=0
- full=0, empty=1
REQ-035 Reset asserted mid-operation SHALL discard queued and in-flight bookkeeping.
REQ-036 After reset release, the first edge SHALL behave as IDLE with an empty queue.

Verification
REQ-037 Write 8'hA5 to an idle empty queue at edge N with tx_busy=0 -> tx_trigger is high exactly one cycle after edge N+1, tx_data=8'hA5, and count returns to 0.
REQ-038 Write 8 bytes 8'h01..8'h08 back-to-back while holding tx_busy=1 -> full=1, count=8; a 9th write sets overflow=1 and count stays 8.
REQ-039 Release tx_busy and pulse tx_done after each trigger -> trigger pulses carry 8'h01..8'h08 in order, each separated by at least one GAP cycle, and the pointers wrap correctly.
REQ-040 Write while full in the same cycle the FSM pops -> the write is accepted, count stays 8, and overflow is unchanged.
REQ-041 Assert flush while in WAIT_DONE with 3 bytes queued -> count=0 and empty=1; the in-flight byte completes on tx_done and no further trigger occurs.
REQ-042 Assert reset=0 during WAIT_DONE with count=5 -> all outputs take their reset values immediately, and a stray tx_done after release is ignored.
